// File: rtl/pb_pkg.sv
// pb_pkg: shared timing defaults for a 10 MHz clock and the per-channel repeat state type
package pb_pkg;
  localparam int PB_DEBOUNCE_10M = 100_000;
  localparam int PB_HOLD_10M = 5_000_000;
  localparam int PB_REPEAT_10M = 1_000_000;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} pb_state_t;
endpackage

// File: rtl/pb_channel.sv
// pb_channel: one button - clk/rst, raw pb in; debounced level plus press/rel/rpt single-cycle pulses out
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_10M,
  parameter int HOLD_CYCLES = PB_HOLD_10M,
  parameter int REPEAT_CYCLES = PB_REPEAT_10M
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = RMAX > 2 ? $clog2(RMAX) : 1;
  logic [1:0] sync;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  pb_state_t state, state_n;
  logic s, flip, rise, fall, fire;
  assign s = sync[1];
  always_comb begin
    flip = s != level && dcnt == DW'(DEBOUNCE_CYCLES - 1);
    rise = flip && s;
    fall = flip && !s;
    dcnt_n = (s == level || flip) ? '0 : dcnt + 1'b1;
    fire = !fall && ((state == HOLD && rcnt == RW'(HOLD_CYCLES - 1)) ||
                     (state == REPEAT && rcnt == RW'(REPEAT_CYCLES - 1)));
    state_n = rise ? HOLD : fall ? IDLE : fire ? REPEAT : state;
    rcnt_n = (rise || fall || fire || state == IDLE) ? '0 : rcnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      dcnt <= '0;
      rcnt <= '0;
      state <= IDLE;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
      rpt <= 1'b0;
    end else begin
      sync <= {sync[0], pb};
      dcnt <= dcnt_n;
      rcnt <= rcnt_n;
      state <= state_n;
      level <= flip ? s : level;
      press <= rise;
      rel <= fall;
      rpt <= fire;
    end
  end
endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: N_BTN independent pb_channel instances - CLOCK/RESET, iPB in; oLEVEL/oPRESS/oRELEASE/oREPEAT out
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int N_BTN = 20,
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_10M,
  parameter int HOLD_CYCLES = PB_HOLD_10M,
  parameter int REPEAT_CYCLES = PB_REPEAT_10M
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic [N_BTN-1:0] iPB,
  output logic [N_BTN-1:0] oLEVEL,
  output logic [N_BTN-1:0] oPRESS,
  output logic [N_BTN-1:0] oRELEASE,
  output logic [N_BTN-1:0] oREPEAT
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk(CLOCK),
      .rst(RESET),
      .pb(iPB[i]),
      .level(oLEVEL[i]),
      .press(oPRESS[i]),
      .rel(oRELEASE[i]),
      .rpt(oREPEAT[i])
    );
  end
endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: vector table, random stimulus against a reference model, and multi-cycle corner sequences
module tb_pb_conditioner;
  localparam int DB = 4;
  localparam int HO = 10;
  localparam int RP = 3;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] pb, lvl, prs, rel, rpt;
  int n_vec = 0;
  int n_bad = 0;
  pb_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HO),
    .REPEAT_CYCLES(RP)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .iPB(pb),
    .oLEVEL(lvl),
    .oPRESS(prs),
    .oRELEASE(rel),
    .oREPEAT(rpt)
  );
  always #5 clk = ~clk;
  logic [3:0] m_lvl, m_prs, m_rel, m_rpt;
  logic [3:0] pipe[$];
  logic [3:0] hist[$];
  longint cyc = 0;
  longint pt[4];
  task automatic model(input logic [3:0] v, input logic r);
    logic [3:0] s;
    longint d;
    logic fl;
    cyc++;
    if (r) begin
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
      m_rpt = '0;
      pipe = '{4'h0, 4'h0};
      hist.delete();
      return;
    end
    s = pipe.pop_front();
    pipe.push_back(v);
    hist.push_back(s);
    if (hist.size() > DB) void'(hist.pop_front());
    for (int c = 0; c < 4; c++) begin
      fl = hist.size() == DB;
      foreach (hist[i]) if (hist[i][c] == m_lvl[c]) fl = 1'b0;
      d = cyc - pt[c];
      m_prs[c] = fl && !m_lvl[c];
      m_rel[c] = fl && m_lvl[c];
      m_rpt[c] = m_lvl[c] && !fl && (d == HO || (d > HO && (d - HO) % RP == 0));
      if (m_prs[c]) pt[c] = cyc;
      if (fl) m_lvl[c] = !m_lvl[c];
    end
  endtask
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step(input logic [3:0] v, input logic r);
    pb = v;
    rst = r;
    @(posedge clk);
    model(v, r);
    #1;
    check("model", {48'h0, lvl, prs, rel, rpt}, {48'h0, m_lvl, m_prs, m_rel, m_rpt});
  endtask
  task automatic seq(input int ch, input logic [63:0] pat, input int rst_at,
                     output logic [63:0] pm, output logic [63:0] rm, output logic [63:0] qm,
                     output logic [63:0] lm, output logic [15:0] at_rst);
    step(4'h0, 1'b1);
    at_rst = 16'hffff;
    for (int t = 0; t < 64; t++) begin
      step({3'b0, pat[t]} << ch, t == rst_at);
      pm[t] = prs[ch];
      rm[t] = rel[ch];
      qm[t] = rpt[ch];
      lm[t] = lvl[ch];
      if (t == rst_at) at_rst = {lvl, prs, rel, rpt};
    end
  endtask
  typedef struct packed {
    logic r;
    logic [3:0] pb;
    logic [15:0] e;
  } vec_t;
  vec_t tbl[15];
  logic [63:0] pm, rm, qm, lm;
  logic [15:0] ar;
  logic [3:0] pr;
  int div;
  initial begin
    tbl = '{
      {1'b1, 4'h0, 16'h0000},
      {1'b0, 4'h9, 16'h0000},
      {1'b0, 4'h9, 16'h0000},
      {1'b0, 4'h9, 16'h0000},
      {1'b0, 4'h9, 16'h0000},
      {1'b0, 4'h9, 16'h0000},
      {1'b0, 4'h9, 16'h9900},
      {1'b0, 4'h9, 16'h9000},
      {1'b0, 4'h0, 16'h9000},
      {1'b0, 4'h0, 16'h9000},
      {1'b0, 4'h0, 16'h9000},
      {1'b0, 4'h0, 16'h9000},
      {1'b0, 4'h0, 16'h9000},
      {1'b0, 4'h0, 16'h0090},
      {1'b0, 4'h0, 16'h0000}
    };
    foreach (tbl[i]) begin
      step(tbl[i].pb, tbl[i].r);
      check($sformatf("table[%0d]", i), {48'h0, lvl, prs, rel, rpt}, {48'h0, tbl[i].e});
    end
    pr = 4'h0;
    div = 3;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) div = (div == 3) ? 40 : 3;
      for (int c = 0; c < 4; c++) if ($urandom_range(0, div - 1) == 0) pr[c] = !pr[c];
      step(pr, $urandom_range(0, 499) == 0);
    end
    seq(1, 64'hFFFF_FFFF_FFFF_FCE7, -1, pm, rm, qm, lm, ar);
    check("bounce_press", pm, 64'd1 << 15);
    check("bounce_level", lm, ~((64'd1 << 15) - 64'd1));
    seq(2, 64'h0000_0000_007F_FFFF, -1, pm, rm, qm, lm, ar);
    check("repeat_press", pm, 64'd1 << 5);
    check("repeat_pulses", qm, (64'd1 << 15) | (64'd1 << 18) | (64'd1 << 21) | (64'd1 << 24) | (64'd1 << 27));
    check("repeat_release", rm, 64'd1 << 28);
    seq(0, 64'h0000_0000_0000_03FF, -1, pm, rm, qm, lm, ar);
    check("collide_press", pm, 64'd1 << 5);
    check("collide_release", rm, 64'd1 << 15);
    check("collide_repeat", qm, 64'd0);
    seq(3, 64'hFFFF_FFFF_FFFF_FFFF, 19, pm, rm, qm, lm, ar);
    check("reset_outputs", {48'h0, ar}, 64'd0);
    check("reset_press", pm, (64'd1 << 5) | (64'd1 << 25));
    check("reset_repeat", qm & 64'hFFFF_FFFF, (64'd1 << 15) | (64'd1 << 18));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
